// File: rtl/shift_accumulator_if.sv
// Beat/result bus between the adder-tree stage, shift_accumulator and its consumer.
// Carries the input beat handshake (in_*) and the result handshake (out_*).
// master: upstream/downstream side; slave: the accumulator itself.
interface shift_accumulator_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 24,
  parameter int SH_W  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_psum;
  logic [SH_W-1:0]         in_shift;
  logic                    in_neg;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_ovf;

  modport master (
    output in_valid, in_psum, in_shift, in_neg, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_psum, in_shift, in_neg, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/shift_accumulator.sv
// Shift-aligns signed partial sums per beat and accumulates them over a group.
// Latency: last beat accepted at edge N -> out_valid/out_acc/out_ovf registered from edge N.
// Backpressure: while a result is held and out_ready is low, in_ready is low.
// Ports: clk, rst (async, active-high); bus (slave modport): in_valid/in_ready/in_psum/
//   in_shift/in_neg/in_last beat side, out_valid/out_ready/out_acc/out_ovf result side.
// Option: define SHIFT_ACC_SATURATE_EN to clamp the accumulator on signed overflow.
module shift_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 24,
  parameter int SH_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  shift_accumulator_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_d;
  logic                    ovf, ovf_d;
  logic signed [ACC_W-1:0] out_acc_q;
  logic                    out_ovf_q;
  logic                    load_out;

  logic signed [ACC_W-1:0] psum_ext;
  logic signed [ACC_W-1:0] term_sh;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] acc_next;
  logic                    ovf_next;
  logic                    beat;

  // in_ready depends only on state and out_ready: a held result blocks new beats
  // unless it is being consumed this same cycle.
  assign bus.in_ready = (state == ACCUM) || bus.out_ready;
  assign beat         = bus.in_valid && bus.in_ready;

  // Bits shifted past ACC_W are simply lost; only a sign flip in the add is flagged.
  assign psum_ext = {{(ACC_W-IN_W){bus.in_psum[IN_W-1]}}, bus.in_psum};
  assign term_sh  = psum_ext << bus.in_shift;
  assign term     = bus.in_neg ? -term_sh : term_sh;
  assign sum      = acc + term;
  assign add_ovf  = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign ovf_next = ovf || add_ovf;

`ifdef SHIFT_ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // On overflow both operands share a sign, which is the sign of the true sum.
  assign acc_next = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_next = sum;
`endif

  // acc/ovf are zeroed when a group closes, so the next beat always starts a
  // fresh group from 0 without a separate first-beat flag.
  always_comb begin
    state_nxt = state;
    acc_d     = acc;
    ovf_d     = ovf;
    load_out  = 1'b0;
    unique case (state)
      ACCUM: begin
        if (beat) begin
          if (bus.in_last) begin
            load_out  = 1'b1;
            acc_d     = '0;
            ovf_d     = 1'b0;
            state_nxt = HOLD;
          end else begin
            acc_d = acc_next;
            ovf_d = ovf_next;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = ACCUM;
          if (beat) begin
            if (bus.in_last) begin
              load_out  = 1'b1;
              acc_d     = '0;
              ovf_d     = 1'b0;
              state_nxt = HOLD;
            end else begin
              acc_d = acc_next;
              ovf_d = ovf_next;
            end
          end
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      ovf       <= 1'b0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_d;
      ovf   <= ovf_d;
      if (load_out) begin
        out_acc_q <= acc_next;
        out_ovf_q <= ovf_next;
      end
    end
  end

  assign bus.out_valid = (state == HOLD);
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_shift_accumulator.sv
// Directed testbench for shift_accumulator: vector table plus hand-written
// sequences for backpressure and asynchronous reset.
// Expected values are hand-computed for IN_W=8, ACC_W=24, SH_W=4.
module tb_shift_accumulator;

  logic clk;
  logic rst;
  int   total;
  int   bad;

`ifdef SHIFT_ACC_SATURATE_EN
  localparam int OVF_POS = 8388607;
  localparam int OVF_NEG = -8388608;
`else
  localparam int OVF_POS = -4292608;
  localparam int OVF_NEG = 4194304;
`endif

  shift_accumulator_if #(.IN_W(8), .ACC_W(24), .SH_W(4)) bus ();

  shift_accumulator #(.IN_W(8), .ACC_W(24), .SH_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              vld;
    logic signed [7:0] psum;
    logic [3:0]        sh;
    logic              neg;
    logic              last;
    logic              e_vld;
    int                e_acc;
    logic              e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic signed [7:0] p, logic [3:0] s, logic n,
                              logic l, logic ev, int ea, logic eo);
    vec_t r;
    r.vld = v; r.psum = p; r.sh = s; r.neg = n; r.last = l;
    r.e_vld = ev; r.e_acc = ea; r.e_ovf = eo;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic signed [7:0] p, logic [3:0] s, logic n,
                       logic l, logic ordy);
    bus.in_valid  = v;
    bus.in_psum   = p;
    bus.in_shift  = s;
    bus.in_neg    = n;
    bus.in_last   = l;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 8'sd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_acc", int'(bus.out_acc), 0);
    chk("reset out_ovf", int'(bus.out_ovf), 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("in_ready after reset", int'(bus.in_ready), 1);

    // Vector table, out_ready held high throughout
    vecs.push_back(mk(1'b1, 8'sd3,   4'd0,  1'b0, 1'b0, 1'b0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd5,   4'd2,  1'b0, 1'b0, 1'b0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd1,   4'd7,  1'b1, 1'b1, 1'b1, -105, 1'b0));
    vecs.push_back(mk(1'b1, -8'sd1,  4'd15, 1'b0, 1'b1, 1'b1, -32768, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd1,   4'd0,  1'b0, 1'b1, 1'b1, 1, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd2,   4'd0,  1'b0, 1'b1, 1'b1, 2, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd3,   4'd0,  1'b0, 1'b1, 1'b1, 3, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd4,   4'd0,  1'b0, 1'b1, 1'b1, 4, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd127, 4'd15, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd127, 4'd15, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 8'sd127, 4'd15, 1'b0, 1'b1, 1'b1, OVF_POS, 1'b1));
    vecs.push_back(mk(1'b1, 8'sd2,   4'd0,  1'b0, 1'b1, 1'b1, 2, 1'b0));
    vecs.push_back(mk(1'b1, 8'h80,   4'd15, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h80,   4'd15, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h80,   4'd15, 1'b0, 1'b1, 1'b1, OVF_NEG, 1'b1));
    vecs.push_back(mk(1'b0, 8'sd0,   4'd0,  1'b0, 1'b0, 1'b0, 0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vld, vecs[i].psum, vecs[i].sh, vecs[i].neg, vecs[i].last, 1'b1);
      #1;
      chk($sformatf("vec%0d in_ready", i), int'(bus.in_ready), 1);
      tick();
      chk($sformatf("vec%0d out_valid", i), int'(bus.out_valid), int'(vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d out_acc", i), int'(bus.out_acc), vecs[i].e_acc);
        chk($sformatf("vec%0d out_ovf", i), int'(bus.out_ovf), int'(vecs[i].e_ovf));
      end
    end

    // Backpressure: result held five cycles, offered beat must not be taken
    drive(1'b1, 8'sd9, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bp result valid", int'(bus.out_valid), 1);
    chk("bp result acc", int'(bus.out_acc), 9);
    drive(1'b1, 8'sd50, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d in_ready", c), int'(bus.in_ready), 0);
      tick();
      chk($sformatf("bp%0d out_valid", c), int'(bus.out_valid), 1);
      chk($sformatf("bp%0d out_acc", c), int'(bus.out_acc), 9);
    end
    drive(1'b1, 8'sd4, 4'd1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("bp release in_ready", int'(bus.in_ready), 1);
    tick();
    chk("bp new group valid", int'(bus.out_valid), 1);
    chk("bp new group acc", int'(bus.out_acc), 8);
    drive(1'b0, 8'sd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp drained valid", int'(bus.out_valid), 0);

    // Reset while a result is held
    drive(1'b1, 8'sd11, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("hold before rst valid", int'(bus.out_valid), 1);
    chk("hold before rst acc", int'(bus.out_acc), 11);
    drive(1'b0, 8'sd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst in hold valid", int'(bus.out_valid), 0);
    chk("rst in hold acc", int'(bus.out_acc), 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Reset mid-group discards partial accumulation
    drive(1'b1, 8'sd10, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'sd20, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("midgroup valid", int'(bus.out_valid), 0);
    drive(1'b0, 8'sd0, 4'd0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midgroup rst valid", int'(bus.out_valid), 0);
    @(negedge clk) rst = 1'b0;
    tick();
    drive(1'b1, 8'sd7, 4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("post rst valid", int'(bus.out_valid), 1);
    chk("post rst acc", int'(bus.out_acc), 7);
    chk("post rst ovf", int'(bus.out_ovf), 0);
    drive(1'b0, 8'sd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
